// File: rtl/output_fill.sv
// Drains PE-array results from the output FIFO into the output feature-map
// buffer, one entry per cycle, writing N*N entries from a latched base.
module output_fill #(
  parameter int ADDR_WIDTH = 16,
  parameter int SIZE_WIDTH = 8
) (
  input  logic                  w_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] initial_address,
  input  logic [SIZE_WIDTH-1:0] output_featuremapsize,
  input  logic                  is_empty,
  output logic [ADDR_WIDTH-1:0] c_address,
  output logic                  write_enable,
  output logic                  read_enable,
  output logic                  done
);

  localparam int CW = 2 * SIZE_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CW-1:0]         total_q, total_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                  we_q;
  logic                  done_q, done_d;

  logic [CW-1:0] n_ext;
  logic [CW-1:0] n_sq;
  logic          size_zero;
  logic          rd_left;
  logic          last_wr;

  assign n_ext     = CW'(output_featuremapsize);
  assign n_sq      = n_ext * n_ext;
  assign size_zero = (output_featuremapsize == '0);

  assign rd_left = (rd_cnt_q < total_q);
  assign last_wr = we_q & (wr_cnt_q == total_q - CW'(1));

  assign read_enable = (state_q == S_RUN) & enable
                     & ~is_empty & rd_left;

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    total_d  = total_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    addr_d   = addr_q;
    done_d   = done_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          base_d   = initial_address;
          total_d  = n_sq;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = size_zero ? S_DONE : S_RUN;
          done_d   = size_zero;
        end
      end
      S_RUN: begin
        // Every pop is written one cycle later, so the pop index
        // equals the write index the registered address serves.
        if (read_enable) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          addr_d   = base_q + ADDR_WIDTH'(rd_cnt_q);
        end
        if (we_q) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (last_wr) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge w_clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      total_q  <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      total_q  <= total_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      addr_q   <= addr_d;
      we_q     <= read_enable;
      done_q   <= done_d;
    end
  end

  assign c_address    = addr_q;
  assign write_enable = we_q;
  assign done         = done_q;

endmodule

// File: tb/tb_output_fill.sv
// Scoreboard bench for output_fill: expected write addresses are queued
// by the stimulus, a negedge monitor pops them and checks handshakes.
module tb_output_fill;

  logic        w_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] initial_address;
  logic [7:0]  n_size;
  logic        is_empty;
  logic [15:0] c_address;
  logic        write_enable;
  logic        read_enable;
  logic        done;

  output_fill #(
    .ADDR_WIDTH(16),
    .SIZE_WIDTH(8)
  ) dut (
    .w_clk                 (w_clk),
    .reset                 (reset),
    .enable                (enable),
    .initial_address       (initial_address),
    .output_featuremapsize (n_size),
    .is_empty              (is_empty),
    .c_address             (c_address),
    .write_enable          (write_enable),
    .read_enable           (read_enable),
    .done                  (done)
  );

  always #5 w_clk = ~w_clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];

  // Reference: phase 0 idle, 1 filling, 2 finished.
  int ph = 0;
  int m_reads = 0;
  int m_writes = 0;
  int m_total = 0;
  bit m_pend = 0;
  bit m_done = 0;
  bit exp_re;
  logic [15:0] exp_a;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge w_clk) begin
    if (reset) begin
      ph = 0;
      m_reads = 0;
      m_writes = 0;
      m_total = 0;
      m_pend = 0;
      m_done = 0;
    end else begin
      exp_re = (ph == 1) && enable && !is_empty
               && (m_reads < m_total);
      chk("read_enable", read_enable, exp_re);
      chk("write_enable", write_enable, m_pend);
      chk("done", done, m_done);
      if (write_enable) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL spurious_write: addr %0h expected none",
                   c_address);
        end else begin
          exp_a = exp_q.pop_front();
          chk("c_address", c_address, exp_a);
        end
      end
      case (ph)
        0: if (enable) begin
          m_total = int'(n_size) * int'(n_size);
          m_reads = 0;
          m_writes = 0;
          ph = (m_total == 0) ? 2 : 1;
          m_done = (m_total == 0);
        end
        1: begin
          if (exp_re) m_reads++;
          if (m_pend) begin
            m_writes++;
            if (m_writes == m_total) begin
              ph = 2;
              m_done = 1;
            end
          end
        end
        default: if (!enable) begin
          ph = 0;
          m_done = 0;
        end
      endcase
      m_pend = exp_re;
    end
  end

  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    is_empty = 1'b1;
    exp_q.delete();
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic start(input logic [15:0] base,
                       input logic [7:0] n);
    logic [15:0] a;
    initial_address = base;
    n_size = n;
    for (int i = 0; i < int'(n) * int'(n); i++) begin
      a = base + 16'(i);
      exp_q.push_back(a);
    end
    enable = 1'b1;
  endtask

  task automatic wait_done(input int emode, input bit rnd_en);
    int cyc;
    cyc = 0;
    forever begin
      step();
      case (emode)
        0: is_empty = 1'b0;
        1: is_empty = ~is_empty;
        default: is_empty = ($urandom_range(0, 3) == 0);
      endcase
      if (rnd_en) enable = ($urandom_range(0, 3) != 0);
      @(negedge w_clk);
      if (done) break;
      cyc++;
      if (cyc > 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL done_timeout: done=%0b expected 1", done);
        break;
      end
    end
    step();
    enable = 1'b0;
    is_empty = 1'b1;
    repeat (2) step();
    chk("leftover_writes", exp_q.size(), 0);
  endtask

  task automatic run_fill(input logic [15:0] base,
                          input logic [7:0] n,
                          input int emode, input bit rnd_en);
    is_empty = 1'b0;
    start(base, n);
    wait_done(emode, rnd_en);
  endtask

  task automatic wait_pulses(input bit use_we, input int cnt);
    int seen;
    int cyc;
    seen = 0;
    cyc = 0;
    while (seen < cnt && cyc < 500) begin
      @(negedge w_clk);
      if (use_we ? write_enable : read_enable) seen++;
      cyc++;
    end
    chk("pulse_count", seen, cnt);
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    is_empty = 1'b1;
    initial_address = 16'h0;
    n_size = 8'd0;
    #1;
    chk("rst_addr", c_address, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_re", read_enable, 0);
    chk("rst_done", done, 0);
    do_reset();

    run_fill(16'h0010, 8'd8, 0, 0);
    run_fill(16'h0010, 8'd8, 1, 0);
    run_fill(16'h1234, 8'd0, 0, 0);
    run_fill(16'hFFFE, 8'd2, 0, 0);
    run_fill(16'h0200, 8'd1, 0, 0);

    // Pause after 5 pops, then resume for the remaining 11.
    is_empty = 1'b0;
    start(16'h0300, 8'd4);
    wait_pulses(1'b0, 5);
    step();
    enable = 1'b0;
    repeat (6) step();
    chk("pause_remaining", exp_q.size(), 11);
    enable = 1'b1;
    wait_done(0, 0);

    // Asynchronous reset in the middle of a fill.
    is_empty = 1'b0;
    start(16'h0100, 8'd8);
    wait_pulses(1'b1, 10);
    @(posedge w_clk);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_addr", c_address, 0);
    chk("mid_rst_we", write_enable, 0);
    chk("mid_rst_re", read_enable, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    enable = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    step();
    run_fill(16'h0100, 8'd3, 0, 0);

    for (int t = 0; t < 20; t++) begin
      logic [15:0] b;
      b = 16'($urandom);
      if (t % 4 == 0) b = 16'hFFF0 + 16'($urandom_range(0, 15));
      run_fill(b, 8'($urandom_range(0, 12)), 2, 1'(t % 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
